// File: rtl/rle_pkg.sv
// Shared types for the binary-mask run-length encoder: default run width,
// reference word layout and the line FSM states.
package rle_pkg;

  localparam int RLE_LEN_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rle_state_e;

  // Word layout at the default width; the encoder builds the same layout at its own LEN_W.
  typedef struct packed {
    logic [RLE_LEN_W-1:0] len;
    logic                 sym;
    logic                 eol;
  } rle_word_t;

endpackage

// File: rtl/rle_run_encoder_if.sv
// Pixel-in / run-word-out valid/ready streams of the run-length encoder.
interface rle_run_encoder_if
  import rle_pkg::*;
#(
  parameter int LEN_W = RLE_LEN_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_sol;
  logic             in_eol;
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] out_len;
  logic             out_sym;
  logic             out_eol;

  modport master (
    output in_valid, in_bit, in_sol, in_eol, out_ready,
    input  in_ready, out_valid, out_len, out_sym, out_eol
  );

  modport slave (
    input  in_valid, in_bit, in_sol, in_eol, out_ready,
    output in_ready, out_valid, out_len, out_sym, out_eol
  );

endinterface

// File: rtl/rle_out_fifo.sv
// Circular word buffer taking up to three pushes and one pop per cycle.
// The head word reads as zero while the buffer is empty.
module rle_out_fifo #(
  parameter  int WORD_W    = 13,
  parameter  int BUF_DEPTH = 4,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [1:0]        push_cnt,
  input  logic [WORD_W-1:0] push_w0,
  input  logic [WORD_W-1:0] push_w1,
  input  logic [WORD_W-1:0] push_w2,
  input  logic              pop,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_word,
  output logic [CNT_W-1:0]  free
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [WORD_W-1:0] mem [BUF_DEPTH];
  logic [WORD_W-1:0] push_w [3];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  used;
  logic              do_pop;

  // Depth need not be a power of two; n <= 3 < depth, so one subtract wraps.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
    if (s >= (PTR_W+1)'(BUF_DEPTH)) s = s - (PTR_W+1)'(BUF_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign push_w[0] = push_w0;
  assign push_w[1] = push_w1;
  assign push_w[2] = push_w2;

  assign rd_valid = (used != '0);
  assign do_pop   = pop & rd_valid;
  assign rd_word  = rd_valid ? mem[rd_ptr] : '0;
  assign free     = CNT_W'(BUF_DEPTH) - used;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < push_cnt) mem[ptr_add(wr_ptr, 2'(i))] <= push_w[i];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      wr_ptr <= ptr_add(wr_ptr, push_cnt);
      if (do_pop) rd_ptr <= ptr_add(rd_ptr, 2'd1);
      used <= used + CNT_W'(push_cnt) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rle_run_encoder.sv
// Line-oriented run-length encoder for 1-bit mask pixels; every line opens
// with a symbol-0 run and runs longer than MAX_RUN are split with a zero run.
//
//   state | meaning
//   IDLE  | between lines, waiting for a pixel marked in_sol
//   RUN   | inside a line, extending the current run
module rle_run_encoder
  import rle_pkg::*;
#(
  parameter int LEN_W     = RLE_LEN_W,
  parameter int BUF_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                reset_n,
  rle_run_encoder_if.slave    bus,
  output logic                err
);

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             sym;
    logic             eol;
  } word_t;

  localparam int               WORD_W  = $bits(word_t);
  localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [LEN_W-1:0] MAX_RUN = '1;

  rle_state_e       state, state_nx;
  logic [LEN_W-1:0] count, count_nx;
  logic             sym, sym_nx, err_nx;
  logic             accept, line_start, rd_valid;
  logic [1:0]       n_push;
  word_t            w [3];
  word_t            rd;
  logic [CNT_W-1:0] free;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    sym_nx     = sym;
    err_nx     = err;
    n_push     = 2'd0;
    line_start = 1'b0;
    w[0]       = '0;
    w[1]       = '0;
    w[2]       = '0;
    if (accept) begin
      if (state == IDLE && !bus.in_sol) begin
        err_nx = 1'b1;
      end else begin
        line_start = (state == IDLE) || bus.in_sol;
        if (state == RUN && bus.in_sol) begin
          w[n_push] = '{len: count, sym: sym, eol: 1'b1};
          n_push    = n_push + 2'd1;
          err_nx    = 1'b1;
        end
        if (line_start) begin
          if (bus.in_bit) begin
            w[n_push] = '{len: '0, sym: 1'b0, eol: 1'b0};
            n_push    = n_push + 2'd1;
          end
          sym_nx   = bus.in_bit;
          count_nx = LEN_W'(1);
        end else if (bus.in_bit != sym) begin
          w[n_push] = '{len: count, sym: sym, eol: 1'b0};
          n_push    = n_push + 2'd1;
          sym_nx    = ~sym;
          count_nx  = LEN_W'(1);
        end else if (count == MAX_RUN) begin
          // Split a saturated run with an empty run of the other symbol.
          w[n_push] = '{len: MAX_RUN, sym: sym, eol: 1'b0};
          w[n_push + 2'd1] = '{len: '0, sym: ~sym, eol: 1'b0};
          n_push    = n_push + 2'd2;
          count_nx  = LEN_W'(1);
        end else begin
          count_nx = count + LEN_W'(1);
        end
        if (bus.in_eol) begin
          w[n_push] = '{len: count_nx, sym: sym_nx, eol: 1'b1};
          n_push    = n_push + 2'd1;
          state_nx  = IDLE;
        end else begin
          state_nx = RUN;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      sym   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      sym   <= sym_nx;
      err   <= err_nx;
    end
  end

  rle_out_fifo #(
    .WORD_W    (WORD_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .push_cnt (n_push),
    .push_w0  (w[0]),
    .push_w1  (w[1]),
    .push_w2  (w[2]),
    .pop      (bus.out_ready),
    .rd_valid (rd_valid),
    .rd_word  (rd),
    .free     (free)
  );

  // Three free slots cover the worst-case three pushes of the next accepted pixel.
  assign bus.in_ready  = (free >= CNT_W'(3));
  assign bus.out_valid = rd_valid;
  assign bus.out_len   = rd.len;
  assign bus.out_sym   = rd.sym;
  assign bus.out_eol   = rd.eol;

endmodule

// File: tb/tb_rle_run_encoder.sv
// Bench for rle_run_encoder: directed lines plus random lines checked against
// a line-level run model, on an 11-bit and a 4-bit instance.
module tb_rle_run_encoder;
  import rle_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_a, err_b;

  always #5 clk = ~clk;

  rle_run_encoder_if #(.LEN_W(11)) if_a ();
  rle_run_encoder_if #(.LEN_W(4))  if_b ();

  rle_run_encoder #(.LEN_W(11), .BUF_DEPTH(4)) dut_a (
    .CLK(clk), .reset_n(rst_n), .bus(if_a.slave), .err(err_a));
  rle_run_encoder #(.LEN_W(4), .BUF_DEPTH(4)) dut_b (
    .CLK(clk), .reset_n(rst_n), .bus(if_b.slave), .err(err_b));

  int        n_vec = 0, n_miss = 0;
  int        rdy_viol = 0, low_a = 0;
  rle_word_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  bit        rr_a = 0, rr_b = 0, rdy_a = 1, rdy_b = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer side: ready pattern, word capture and an empty-buffer ready check.
  always @(negedge clk) begin
    if_a.out_ready = rr_a ? 1'($urandom_range(0, 1)) : rdy_a;
    if_b.out_ready = rr_b ? 1'($urandom_range(0, 1)) : rdy_b;
    if (rst_n) begin
      if (if_a.out_valid && if_a.out_ready)
        got_a.push_back('{len: if_a.out_len, sym: if_a.out_sym, eol: if_a.out_eol});
      if (if_b.out_valid && if_b.out_ready)
        got_b.push_back('{len: 11'(if_b.out_len), sym: if_b.out_sym, eol: if_b.out_eol});
      if (!if_a.out_valid && !if_a.in_ready) rdy_viol++;
      if (!if_b.out_valid && !if_b.in_ready) rdy_viol++;
      if (!if_a.in_ready) low_a++;
    end
  end

  task automatic drive(input int sel, input logic v, input logic b, input logic s, input logic e);
    if (sel == 0) begin
      if_a.in_valid = v; if_a.in_bit = b; if_a.in_sol = s; if_a.in_eol = e;
    end else begin
      if_b.in_valid = v; if_b.in_bit = b; if_b.in_sol = s; if_b.in_eol = e;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_px(input int sel, input logic b, input logic s, input logic e);
    int   guard;
    logic acc;
    guard = 0;
    drive(sel, 1'b1, b, s, e);
    do begin
      acc = (sel == 0) ? if_a.in_ready : if_b.in_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end while (!acc && guard < 500);
    if (!acc) check_eq("px_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_line(input int sel, input bit bits[$], input bit gaps);
    for (int i = 0; i < bits.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
      end
      send_px(sel, bits[i], i == 0, i == bits.size() - 1);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input int sel, input int len, input bit sym, input bit eol);
    rle_word_t w;
    w.len = 11'(len); w.sym = sym; w.eol = eol;
    if (sel == 0) exp_a.push_back(w); else exp_b.push_back(w);
  endtask

  // A run of L pixels becomes max_run chunks separated by empty opposite runs.
  task automatic emit(input int sel, input int max_run, input int len, input bit s, input bit e);
    while (len > max_run) begin
      add(sel, max_run, s, 1'b0);
      add(sel, 0, ~s, 1'b0);
      len -= max_run;
    end
    add(sel, len, s, e);
  endtask

  task automatic model_line(input int sel, input bit bits[$]);
    int max_run, run;
    bit s;
    max_run = (sel == 0) ? 2047 : 15;
    s = 1'b0;
    run = 0;
    foreach (bits[i]) begin
      if (bits[i] == s) run++;
      else begin
        emit(sel, max_run, run, s, 1'b0);
        s = ~s;
        run = 1;
      end
    end
    emit(sel, max_run, run, s, 1'b1);
  endtask

  task automatic drain_cmp(input int sel, input string tag, input bit bits[$], input bit dec);
    int        guard, n, sum, viol, derr, idx;
    bit        ps;
    rle_word_t g[$], e[$];
    guard = 0;
    while ((sel == 0 ? (got_a.size() < exp_a.size() || if_a.out_valid)
                     : (got_b.size() < exp_b.size() || if_b.out_valid)) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check_eq({tag, "_drain_timeout"}, 32'd0, 32'd1);
    if (sel == 0) begin g = got_a; e = exp_a; got_a.delete(); exp_a.delete(); end
    else begin g = got_b; e = exp_b; got_b.delete(); exp_b.delete(); end
    check_eq({tag, "_nwords"}, g.size(), e.size());
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_w%0d", tag, i), 32'(g[i]), 32'(e[i]));
    if (dec) begin
      sum = 0; viol = 0; derr = 0; idx = 0; ps = 1'b1;
      foreach (g[i]) begin
        if (g[i].sym == ps) viol++;
        if (g[i].eol != (i == g.size() - 1)) viol++;
        ps = g[i].sym;
        for (int k = 0; k < int'(g[i].len); k++) begin
          if (idx >= bits.size() || bits[idx] != g[i].sym) derr++;
          idx++;
        end
        sum += int'(g[i].len);
      end
      check_eq({tag, "_len_sum"}, sum, bits.size());
      check_eq({tag, "_alternation"}, viol, 0);
      check_eq({tag, "_decode"}, derr, 0);
    end
  endtask

  initial begin
    bit q[$];
    bit cur;
    int tog;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", if_a.out_valid, 0);
    check_eq("rst_out_len", if_a.out_len, 0);
    check_eq("rst_out_sym", if_a.out_sym, 0);
    check_eq("rst_out_eol", if_a.out_eol, 0);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_out_valid_b", if_b.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("in_ready_after_rst", if_a.in_ready, 1);
    check_eq("in_ready_after_rst_b", if_b.in_ready, 1);

    q = '{0, 0, 0, 1, 1, 0};
    send_line(0, q, 0);
    add(0, 3, 0, 0); add(0, 2, 1, 0); add(0, 1, 0, 1);
    drain_cmp(0, "line_000110", q, 0);
    check_eq("err_clean_line", err_a, 0);

    q = '{1, 1, 0, 0, 0};
    send_line(0, q, 0);
    add(0, 0, 0, 0); add(0, 2, 1, 0); add(0, 3, 0, 1);
    drain_cmp(0, "line_11000", q, 0);

    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(1'b0);
    send_line(1, q, 0);
    add(1, 15, 0, 0); add(1, 0, 1, 0); add(1, 5, 0, 1);
    drain_cmp(1, "sat_20_zeros", q, 1);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(1'b1);
    send_line(1, q, 0);
    add(1, 0, 0, 0); add(1, 15, 1, 0); add(1, 0, 0, 0); add(1, 1, 1, 1);
    drain_cmp(1, "sat_16_ones", q, 1);

    q = '{0};
    send_line(0, q, 0);
    add(0, 1, 0, 1);
    drain_cmp(0, "one_px_0", q, 0);
    q = '{1};
    send_line(0, q, 0);
    add(0, 0, 0, 0); add(0, 1, 1, 1);
    drain_cmp(0, "one_px_1", q, 0);
    check_eq("err_after_legal_lines", err_a, 0);

    rr_a = 1;
    for (int k = 0; k < 6; k++) begin
      tog = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 4 : 16);
      q.delete();
      cur = 1'($urandom_range(0, 1));
      for (int i = 0; i < 640; i++) begin
        if ($urandom_range(0, tog - 1) == 0) cur = ~cur;
        q.push_back(cur);
      end
      model_line(0, q);
      send_line(0, q, 1);
      drain_cmp(0, $sformatf("rand_a%0d", k), q, 1);
    end
    rr_a = 0;
    check_eq("rdy_backpressure_seen", low_a > 0, 1);

    rr_b = 1;
    for (int k = 0; k < 2; k++) begin
      q.delete();
      cur = 1'($urandom_range(0, 1));
      for (int i = 0; i < 640; i++) begin
        if ($urandom_range(0, 39) == 0) cur = ~cur;
        q.push_back(cur);
      end
      model_line(1, q);
      send_line(1, q, 1);
      drain_cmp(1, $sformatf("rand_b%0d", k), q, 1);
    end
    rr_b = 0;

    send_px(0, 1'b1, 1'b0, 1'b0);
    send_px(0, 1'b0, 1'b0, 1'b0);
    send_px(0, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    q.delete();
    drain_cmp(0, "drop_no_sol", q, 0);
    check_eq("err_no_sol", err_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("err_cleared_by_rst", err_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_px(0, 1'b0, 1'b1, 1'b0);
    send_px(0, 1'b0, 1'b0, 1'b0);
    send_px(0, 1'b1, 1'b0, 1'b0);
    send_px(0, 1'b1, 1'b0, 1'b0);
    send_px(0, 1'b1, 1'b1, 1'b0);
    send_px(0, 1'b1, 1'b0, 1'b0);
    send_px(0, 1'b0, 1'b0, 1'b0);
    send_px(0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 2, 0, 0); add(0, 2, 1, 1); add(0, 0, 0, 0); add(0, 2, 1, 0); add(0, 2, 0, 1);
    drain_cmp(0, "sol_restart", q, 0);
    check_eq("err_restart", err_a, 1);

    rdy_a = 0;
    repeat (2) @(negedge clk);
    send_px(0, 1'b0, 1'b1, 1'b0);
    send_px(0, 1'b1, 1'b0, 1'b0);
    send_px(0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_valid", if_a.out_valid, 1);
    check_eq("in_ready_low_two_buffered", if_a.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midline_rst_out_valid", if_a.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_a = 1;
    got_a.delete();
    exp_a.delete();
    repeat (2) @(negedge clk);
    q = '{1, 0};
    send_line(0, q, 0);
    add(0, 0, 0, 0); add(0, 1, 1, 0); add(0, 1, 0, 1);
    drain_cmp(0, "after_midline_rst", q, 1);

    check_eq("ready_low_while_empty", rdy_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rle_run_encoder.md
# rle_run_encoder

Run-length encoder for binary mask pixels from the colour-filter stage in the rover vision pipeline. Converts one line of 1-bit pixels into alternating run-length words that the on-chip RLE decoder and the downstream FIFO/UART path consume. Every line starts with a symbol-0 run. Runs are words of `LEN_W` bits. Backpressure on both sides uses valid/ready.

## Interface
Parameters:
- `LEN_W`, 11: run-length width. `MAX_RUN` = 2^`LEN_W`-1.
- `BUF_DEPTH`, 4: output buffer entries. Must be at least 4.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: pixel present.
- `in_ready` out 1: encoder accepts a pixel. Equals 1 when the buffer has 3 or more free entries.
- `in_bit` in 1: mask pixel.
- `in_sol` in 1: marks the first pixel of a line.
- `in_eol` in 1: marks the last pixel of a line.
- `out_valid` out 1: run word available.
- `out_ready` in 1: consumer takes the word.
- `out_len` out `LEN_W`: run length, range 0..`MAX_RUN`.
- `out_sym` out 1: symbol of the run.
- `out_eol` out 1: last run of the line.
- `err` out 1: sticky protocol-error flag. Cleared only by reset.

## Operation
- A pixel is accepted on a cycle with `in_valid` & `in_ready`. Only accepted pixels change state.
- FSM `IDLE`:
  - A pixel without `in_sol` is dropped and sets `err`.
  - A pixel with `in_sol` starts a line, symbol 0, then goes to `RUN`.
  - Line start with `in_bit`=1: push (0,0) first, then the current symbol is 1.
  - `count` is set to 1.
- FSM `RUN`, in the order below. Up to 3 words are pushed per cycle, in this order:
  - `in_sol` (line restart): push (`count`, sym, eol=1), set `err`, then treat the pixel as a line start, same as in `IDLE`.
  - `in_bit` differs from the current symbol: push (`count`, sym). Toggle the symbol. Set `count`=1.
  - Same bit with `count`==`MAX_RUN` (saturation): push (`MAX_RUN`, sym) and (0, !sym). The symbol stays. Set `count`=1.
  - Same bit, not saturated: `count`+1.
  - `in_eol` after the steps above: push (`count`, sym, eol=1) using the updated `count`. Go to `IDLE`.
- `count` is `LEN_W` bits wide and never wraps. A saturated run is split, never truncated.
- Run symbols strictly alternate within a line. The first run of a line is always symbol 0.
- The sum of the `out_len` values in a line equals the number of accepted pixels in that line.
- The output buffer is a FIFO. Words leave in push order with no loss or duplication.

## Timing
- Reset values:
  - `out_valid`=0, `out_len`=0, `out_sym`=0, `out_eol`=0, `err`=0.
  - Buffer empty, FSM in `IDLE`, `count`=0, symbol 0.
  - `in_ready`=1 from the first edge after `reset_n` releases.
- Latency: a word pushed at edge N is visible with `out_valid`=1 after edge N when the buffer was empty. Otherwise it waits behind older words.
- `in_ready` is registered from buffer occupancy. A pop and a push in the same cycle are both applied.
- While `out_valid`=1 and `out_ready`=0, `out_len`, `out_sym` and `out_eol` are held stable.
- Full throughput (1 pixel per cycle) when `out_ready` is held at 1.
- Reset mid-line drops the partial run and all buffered words. No word is emitted for the aborted line.
- One-pixel line (`in_sol` and `in_eol` together) is legal:
  - bit 0 gives (1,0,eol).
  - bit 1 gives (0,0), (1,1,eol).

## Structure
- Package `rle_pkg`: default `LEN_W`, a word struct {len, sym, eol}, and the FSM state enum (`IDLE`, `RUN`).
- Sub-module `rle_out_fifo`:
  - `BUF_DEPTH`-entry circular buffer.
  - Push-count input 0..3 with three word inputs, plus a single-pop port.
  - Free-entry count output, which drives `in_ready`.
- The encoder core holds the FSM, `count`, the symbol register, `err`, and the push-word selection.

## Test plan
- Line 0,0,0,1,1,0 (`in_sol` on first, `in_eol` on last) -> (3,0), (2,1), (1,0,eol); `err`=0.
- Line 1,1,0,0,0 -> (0,0), (2,1), (3,0,eol).
- `LEN_W`=4, 20 zeros in one line -> (15,0), (0,1), (5,0,eol). Then 16 ones with saturation and `in_eol` on the 16th pixel -> (0,0), (15,1), (0,0), (1,1,eol).
- Random 640-pixel lines with `out_ready` toggled randomly:
  - `in_ready` drops whenever free < 3.
  - No words lost.
  - Per-line length sum is 640 and symbols alternate.
  - Decoding the words reproduces the input bits.
- Pixels before any `in_sol` are dropped and `err`=1. `in_sol` at pixel 5 of a line -> (`count`, sym, eol=1), then the new line is encoded normally.
- Assert `reset_n` mid-line with 2 words buffered -> `out_valid`=0 immediately. After release the next line is encoded with no stale words.
